// File: rtl/div_share_arb.sv
// Round-robin front end that shares one multi-cycle divider among NREQ requesters,
// with a divide-by-zero bypass and a watchdog against a divider that never completes.
module div_share_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_dividend,
    input  logic [32*NREQ-1:0]   req_divisor,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_qut,
    output logic [31:0]          rsp_rmd,
    output logic                 rsp_dz,
    output logic                 rsp_err,
    output logic                 div_start,
    output logic [31:0]          div_src1,
    output logic [31:0]          div_src2,
    input  logic [31:0]          div_qut,
    input  logic [31:0]          div_rmd,
    input  logic                 div_done
);

    localparam int OW_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [OW_W-1:0] OW_LAST  = OW_W'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_reg;
    logic [OW_W-1:0]   rr_reg;
    logic [OW_W-1:0]   owner_reg;
    logic [WD_W-1:0]   wd_reg;
    logic [31:0]       src1_reg;
    logic [31:0]       src2_reg;
    logic [31:0]       qut_reg;
    logic [31:0]       rmd_reg;
    logic              dz_reg;
    logic              err_reg;
    logic              start_reg;
    logic [NREQ-1:0]   rsp_valid_reg;

    logic [OW_W-1:0]   grant;
    logic              grant_vld;
    logic [31:0]       dvd [NREQ];
    logic [31:0]       dvs [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign dvd[gi] = req_dividend[32*gi +: 32];
            assign dvs[gi] = req_divisor[32*gi +: 32];
        end
    endgenerate

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_reg) + i) % NREQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = OW_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && grant_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            rr_reg        <= '0;
            owner_reg     <= '0;
            wd_reg        <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            qut_reg       <= '0;
            rmd_reg       <= '0;
            dz_reg        <= 1'b0;
            err_reg       <= 1'b0;
            start_reg     <= 1'b0;
            rsp_valid_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_vld) begin
                        owner_reg <= grant;
                        src1_reg  <= dvd[grant];
                        src2_reg  <= dvs[grant];
                        if (dvs[grant] == 32'd0) begin
                            qut_reg       <= 32'hFFFF_FFFF;
                            rmd_reg       <= dvd[grant];
                            dz_reg        <= 1'b1;
                            err_reg       <= 1'b0;
                            rsp_valid_reg <= ONE_HOT0 << grant;
                            state_reg     <= RESP;
                        end else begin
                            start_reg <= 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    start_reg <= 1'b0;
                    wd_reg    <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // Done wins over a watchdog expiring in the same cycle.
                    if (div_done) begin
                        qut_reg       <= div_qut;
                        rmd_reg       <= div_rmd;
                        dz_reg        <= 1'b0;
                        err_reg       <= 1'b0;
                        rsp_valid_reg <= ONE_HOT0 << owner_reg;
                        state_reg     <= RESP;
                    end else if (wd_reg == WD_LAST) begin
                        qut_reg       <= '0;
                        rmd_reg       <= '0;
                        dz_reg        <= 1'b0;
                        err_reg       <= 1'b1;
                        rsp_valid_reg <= ONE_HOT0 << owner_reg;
                        state_reg     <= RESP;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        rr_reg        <= (owner_reg == OW_LAST) ? '0 : owner_reg + OW_W'(1);
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_qut   = qut_reg;
    assign rsp_rmd   = rmd_reg;
    assign rsp_dz    = dz_reg;
    assign rsp_err   = err_reg;
    assign div_start = start_reg;
    assign div_src1  = src1_reg;
    assign div_src2  = src2_reg;

endmodule

// File: tb/tb_div_share_arb.sv
// Scoreboard bench for div_share_arb: directed requests, a 33-cycle divider stub,
// and a monitor that checks every response handshake against queued expectations.
module tb_div_share_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic                 clk;
    logic                 n_rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_dividend;
    logic [32*NREQ-1:0]   req_divisor;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          rsp_qut;
    logic [31:0]          rsp_rmd;
    logic                 rsp_dz;
    logic                 rsp_err;
    logic                 div_start;
    logic [31:0]          div_src1;
    logic [31:0]          div_src2;
    logic [31:0]          div_qut;
    logic [31:0]          div_rmd;
    logic                 div_done;

    div_share_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_qut(rsp_qut), .rsp_rmd(rsp_rmd), .rsp_dz(rsp_dz), .rsp_err(rsp_err),
        .div_start(div_start), .div_src1(div_src1), .div_src2(div_src2),
        .div_qut(div_qut), .div_rmd(div_rmd), .div_done(div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stub: start in cycle N gives done in cycle N+33.
    logic [5:0]  cnt_reg;
    logic [31:0] ma_reg, mb_reg;
    logic        hang;
    logic        stray;
    initial cnt_reg = '0;
    always @(posedge clk) begin
        if (div_start) begin
            cnt_reg <= 6'd33;
            ma_reg  <= div_src1;
            mb_reg  <= div_src2;
        end else if (cnt_reg != 0) begin
            cnt_reg <= cnt_reg - 6'd1;
        end
    end
    assign div_done = (cnt_reg == 6'd1 && !hang) || stray;
    assign div_qut  = (mb_reg != 0) ? ma_reg / mb_reg : 32'd0;
    assign div_rmd  = (mb_reg != 0) ? ma_reg % mb_reg : 32'd0;

    typedef struct {
        int          owner;
        logic [31:0] qut;
        logic [31:0] rmd;
        logic        dz;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int o, input logic [31:0] q, input logic [31:0] r,
                        input logic dz, input logic err);
        exp_t e;
        e.owner = o; e.qut = q; e.rmd = r; e.dz = dz; e.err = err;
        sb.push_back(e);
    endtask

    // Monitor: one comparison set per response handshake.
    always @(negedge clk) begin
        if (n_rst && (rsp_valid & rsp_ready) != 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("rsp owner=%0d qut=0x%08h rmd=0x%08h dz=%0b err=%0b",
                         e.owner, rsp_qut, rsp_rmd, rsp_dz, rsp_err);
                chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.owner));
                chk("rsp_qut",   64'(rsp_qut),   64'(e.qut));
                chk("rsp_rmd",   64'(rsp_rmd),   64'(e.rmd));
                chk("rsp_dz",    64'(rsp_dz),    64'(e.dz));
                chk("rsp_err",   64'(rsp_err),   64'(e.err));
            end
        end
    end

    // Presents one request in cycle 0, drops it after the accept edge (returns in cycle 1).
    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        req_valid[idx] = 1'b1;
        req_dividend[32*idx +: 32] = a;
        req_divisor[32*idx +: 32]  = b;
        @(negedge clk);
        chk("req_ready_accept", 64'(req_ready), 64'(4'b0001 << idx));
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    // Cycle of first rsp_valid and of div_start, counted from the accept cycle.
    task automatic wait_rsp(output int c, output int ds);
        c  = 1;
        ds = -1;
        forever begin
            @(negedge clk);
            if (div_start) ds = c;
            if (rsp_valid != 0 || c >= 200) break;
            c++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    int c, ds, g, n;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] q0, r0;
    logic        stable, no_rdy, seen;

    initial begin
        n_rst = 1'b0; hang = 1'b0; stray = 1'b0;
        req_valid = '0; rsp_ready = 4'b1111;
        req_dividend = '0; req_divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_rsp_bus",   64'({rsp_qut, rsp_rmd}), 64'd0);
        chk("rst_flags",     64'({rsp_dz, rsp_err}), 64'd0);
        chk("rst_div_src",   64'({div_src1, div_src2}), 64'd0);
        @(posedge clk); #1 n_rst = 1'b1;

        // All four requesters at once; req0 stays valid to be granted again after 3.
        push(0, 333, 1, 0, 0); push(1, 666, 2, 0, 0); push(2, 1000, 0, 0, 0);
        push(3, 1333, 1, 0, 0); push(0, 333, 1, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[32*i +: 32] = 32'(1000 * (i + 1));
            req_divisor[32*i +: 32]  = 32'd3;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            g = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            chk("rr_grant_order", 64'(g), 64'(order[k]));
            @(posedge clk); #1;
            if (k != 0 && g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        drain();

        // Single request, normal latency.
        push(0, 14, 2, 0, 0);
        issue(0, 100, 7);
        wait_rsp(c, ds);
        chk("t1_rsp_cycle", 64'(c), 64'd35);
        chk("t1_start_cycle", 64'(ds), 64'd1);
        drain();

        // Divide by zero bypasses the divider.
        push(2, 32'hFFFF_FFFF, 32'h1234, 1, 0);
        issue(2, 32'h1234, 0);
        wait_rsp(c, ds);
        chk("dz_rsp_cycle", 64'(c), 64'd1);
        chk("dz_no_start", 64'(ds), 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // Backpressure on owner 1 while requester 3 waits.
        rsp_ready = 4'b1101;
        push(1, 10, 0, 0, 0);
        push(3, 4, 1, 0, 0);
        issue(1, 50, 5);
        req_dividend[96 +: 32] = 32'd9;
        req_divisor[96 +: 32]  = 32'd2;
        req_valid[3] = 1'b1;
        wait_rsp(c, ds);
        chk("bp_rsp_cycle", 64'(c), 64'd35);
        q0 = rsp_qut; r0 = rsp_rmd;
        stable = 1'b1; no_rdy = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid != 4'b0010 || rsp_qut != q0 || rsp_rmd != r0 || rsp_dz || rsp_err)
                stable = 1'b0;
            if (req_ready != 0) no_rdy = 1'b0;
        end
        chk("bp_rsp_stable", 64'(stable), 64'd1);
        chk("bp_no_ready3", 64'(no_rdy), 64'd1);
        @(posedge clk); #1 rsp_ready = 4'b1111;
        @(negedge clk);
        chk("bp_ready3_hs_cycle", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bp_ready3_after", 64'(req_ready), 64'b1000);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        drain();

        // Hung divider trips the watchdog; next request is normal.
        hang = 1'b1;
        push(0, 0, 0, 0, 1);
        issue(0, 77, 7);
        wait_rsp(c, ds);
        chk("to_rsp_cycle", 64'(c), 64'(2 + TIMEOUT));
        drain();
        hang = 1'b0;
        push(0, 9, 0, 0, 0);
        issue(0, 81, 9);
        wait_rsp(c, ds);
        chk("after_to_cycle", 64'(c), 64'd35);
        drain();

        // Reset in WAIT abandons the transaction; stray done pulses are ignored.
        issue(2, 500, 4);
        repeat (4) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        chk("mid_rst_outputs", 64'({rsp_valid, div_start, rsp_dz, rsp_err}), 64'd0);
        chk("mid_rst_src", 64'({div_src1, div_src2}), 64'd0);
        @(posedge clk); #1 n_rst = 1'b1;
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid != 0 || div_start) seen = 1'b1;
        end
        chk("stray_done_ignored", 64'(seen), 64'd0);
        push(1, 32'h0FFF_FFFF, 32'hF, 0, 0);
        issue(1, 32'hFFFF_FFFF, 32'h10);
        wait_rsp(c, ds);
        chk("post_rst_cycle", 64'(c), 64'd35);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
- Shares one 32-bit non-restoring divider (div32) among NREQ requesters.
- Arbitrates round-robin and sequences the divider's start/done protocol.
- Returns quotient and remainder to the granted requester.
- Short-circuits divide-by-zero without using the divider, and applies a watchdog so a hung divider cannot stall requesters indefinitely.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before abort (must exceed 33)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending, per requester
req_ready  out  NREQ  one-hot accept pulse
req_dividend  in  32*NREQ  dividend, requester i at [32i+31:32i]
req_divisor  in  32*NREQ  divisor, same packing
rsp_valid  out  NREQ  one-hot response valid to owner
rsp_ready  in  NREQ  response accept, per requester
rsp_qut  out  32  quotient (shared bus)
rsp_rmd  out  32  remainder (shared bus)
rsp_dz  out  1  divide-by-zero flag, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
div_start  out  1  divider start pulse
div_src1  out  32  divider dividend
div_src2  out  32  divider divisor
div_qut  in  32  divider quotient
div_rmd  in  32  divider remainder
div_done  in  1  divider done pulse

Behaviour:
Reset (async, n_rst low):
- All outputs 0; FSM=IDLE; rr pointer=0; operand/result regs 0; watchdog=0.
- Reset mid-operation abandons the transaction; no response is issued.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Grant = first asserted req_valid searching from rr pointer upward, wrapping at NREQ.
- On grant g (combinational in the same cycle):
  - req_ready[g]=1 for exactly one cycle.
  - Latch dividend/divisor and owner=g.
- If latched divisor==0: qut=32'hFFFF_FFFF, rmd=dividend, dz=1, go RESP.
- Otherwise go ISSUE.
- No req_valid: stay in IDLE.

ISSUE:
- div_start=1 for exactly one cycle; div_src1/div_src2 driven from latched regs.
- Go WAIT; clear watchdog.

WAIT:
- div_src1/div_src2 stay held; div_start=0.
- div_done=1: latch div_qut/div_rmd, dz=0, err=0, go RESP.
- Watchdog reaches TIMEOUT first: qut=0, rmd=0, err=1, go RESP.
- A div_done arriving outside WAIT is ignored.

RESP:
- rsp_valid[owner]=1 with rsp_qut/rsp_rmd/rsp_dz/rsp_err stable until rsp_ready[owner]=1.
- On handshake: go IDLE; rr pointer=(owner+1) mod NREQ.
- rsp_ready of non-owners is ignored.

General rules:
- rsp_* buses are held between responses; outputs are registered except req_ready.
- div_start is never asserted while a transaction is outstanding (only in ISSUE).
- Latency, accept in cycle 0: div_start in cycle 1; divider returns div_done in cycle 34; rsp_valid from cycle 35. Divide-by-zero: rsp_valid in cycle 1.
- Throughput: one transaction in flight.
- req_valid may drop without acceptance (no penalty).
- Requester operands are sampled only in the accept cycle.
- Simultaneous requests: only one is granted per IDLE visit. A requester is never granted twice while another is continuously valid, so the wait is bounded to NREQ-1 transactions.
- Owner's req_valid in RESP: has no effect until the FSM returns to IDLE.

Test Plan:
1. Single req0: dividend=100, divisor=7 → req_ready[0] cycle 0, div_start cycle 1, rsp_valid=4'b0001 cycle 35, qut=14, rmd=2, dz=0, err=0.
2. All four valid at once, with rsp_ready tied 1 → grant order 0,1,2,3, then 0 again. Use dividends 1000,2000,3000,4000 with divisor 3 → qut 333/666/1000/1333, rmd 1/2/0/1.
3. req2 divisor=0, dividend=0x1234 → no div_start; rsp_valid=4'b0100 in cycle 1, qut=0xFFFFFFFF, rmd=0x1234, dz=1.
4. Backpressure: rsp_ready[1] held low 10 cycles → rsp_valid and data stable throughout. With req3 also valid meanwhile, no req_ready[3] until the cycle after the handshake.
5. div_done stubbed never-asserting → rsp_valid in cycle 2+TIMEOUT, err=1, qut=0, rmd=0; the next request then proceeds normally.
6. n_rst pulsed low in WAIT → all outputs 0 immediately; after release, stray div_done is ignored. A new req1 (0xFFFFFFFF / 0x10) → qut=0x0FFFFFFF, rmd=0xF.
